alu_arbiter: RTL and testbench

Two-requester arbiter and sequencer that shares the single combinational `alu` between two clients. It registers one client's operands and ALUControl, holds them on the ALU inputs for one execute cycle, captures ALUOutput, and returns the result over a valid/ready response channel. It sits between the two issuing units and the `alu` instance, and is the only driver of the `alu` inputs.

---
 rtl/alu_arbiter.sv | 82 ++++++++
 tb/tb_alu_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter/sequencer sharing one combinational ALU over valid/ready channels.
// Optional ALU_ARB_OPCHECK_EN: op 000 is answered directly with rsp_err=1 and result 0, skipping EXEC.
module alu_arbiter #(
  parameter int RR_EN_PARAM = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_err,
  output logic [31:0]      alu_dr1,
  output logic [31:0]      alu_dr2,
  output logic [2:0]       alu_ctrl,
  input  logic [31:0]      alu_result,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic last_grant, gid, win, acc, rsp_done, zero_op;
  // win selects requester 1; on a tie round-robin favours whoever was not granted last
  always_comb begin
    win = req0_valid ? (req1_valid && RR_EN_PARAM != 0 && !last_grant) : 1'b1;
    req0_ready = state == IDLE && req0_valid && !win;
    req1_ready = state == IDLE && req1_valid && win;
    acc = req0_ready || req1_ready;
    rsp0_valid = state == RESP && !gid;
    rsp1_valid = state == RESP && gid;
    rsp_done = gid ? rsp1_valid && rsp1_ready : rsp0_valid && rsp0_ready;
    busy = state != IDLE;
    state_nx = state;
    state_nx = state == IDLE ? (acc ? (zero_op ? RESP : EXEC) : IDLE) :
               state == EXEC ? RESP : (rsp_done ? IDLE : RESP);
  end
`ifdef ALU_ARB_OPCHECK_EN
  assign zero_op = (win ? req1_op : req0_op) == 3'b000;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rsp_err <= 1'b0;
    else if (state == EXEC) rsp_err <= 1'b0;
    else if (acc && zero_op) rsp_err <= 1'b1;
`else
  assign zero_op = 1'b0;
  assign rsp_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= 1'b1;
      gid <= 1'b0;
      alu_dr1 <= '0;
      alu_dr2 <= '0;
      alu_ctrl <= 3'b000;
      rsp_result <= '0;
      ops_done <= '0;
    end else begin
      state <= state_nx;
      if (acc) begin
        alu_dr1 <= win ? req1_a : req0_a;
        alu_dr2 <= win ? req1_b : req0_b;
        alu_ctrl <= win ? req1_op : req0_op;
        gid <= win;
        last_grant <= win;
      end
      if (state == EXEC) rsp_result <= alu_result;
      else if (acc && zero_op) rsp_result <= '0;
      if (rsp_done) ops_done <= ops_done + CNT_W'(1);
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of arbitration, sequencing, backpressure, reset and counter wrap.
module tb_alu_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic req0_valid, req0_ready, req1_valid, req1_ready, rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready, rsp_err, busy;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, rsp_result, alu_dr1, alu_dr2, alu_result;
  logic [2:0] req0_op, req1_op, alu_ctrl;
  logic [15:0] ops_done;
  logic f_req0_valid, f_req0_ready, f_req1_valid, f_req1_ready, f_rsp0_valid, f_rsp0_ready, f_rsp1_valid, f_rsp1_ready, f_rsp_err, f_busy;
  logic [31:0] f_req0_a, f_req0_b, f_req1_a, f_req1_b, f_rsp_result, f_alu_dr1, f_alu_dr2, f_alu_result;
  logic [2:0] f_req0_op, f_req1_op, f_alu_ctrl;
  logic [1:0] f_ops_done;
  int n_chk = 0, n_err = 0;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    case (op)
      3'b001: return a + b;
      3'b010: return a - b;
      3'b011: return {31'b0, a > b};
      3'b100: return a & b;
      3'b101: return a | b;
      3'b110: return a ^ b;
      3'b111: return ~(a | b);
      default: return 32'h0;
    endcase
  endfunction
  assign alu_result = alu_f(alu_dr1, alu_dr2, alu_ctrl);
  assign f_alu_result = alu_f(f_alu_dr1, f_alu_dr2, f_alu_ctrl);

  alu_arbiter u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .alu_dr1(alu_dr1), .alu_dr2(alu_dr2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .busy(busy), .ops_done(ops_done)
  );
  alu_arbiter #(.RR_EN_PARAM(0), .CNT_W(2)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_a(f_req0_a), .req0_b(f_req0_b), .req0_op(f_req0_op),
    .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_a(f_req1_a), .req1_b(f_req1_b), .req1_op(f_req1_op),
    .rsp0_valid(f_rsp0_valid), .rsp0_ready(f_rsp0_ready), .rsp1_valid(f_rsp1_valid), .rsp1_ready(f_rsp1_ready),
    .rsp_result(f_rsp_result), .rsp_err(f_rsp_err), .alu_dr1(f_alu_dr1), .alu_dr2(f_alu_dr2), .alu_ctrl(f_alu_ctrl),
    .alu_result(f_alu_result), .busy(f_busy), .ops_done(f_ops_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #2;
  endtask
  task automatic pulse_reset;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    {req0_valid, req1_valid, rsp0_ready, rsp1_ready} = '0;
    {req0_a, req0_b, req1_a, req1_b, req0_op, req1_op} = '0;
    {f_req0_valid, f_req1_valid, f_rsp0_ready, f_rsp1_ready} = '0;
    {f_req0_a, f_req0_b, f_req1_a, f_req1_b, f_req0_op, f_req1_op} = '0;
    step;
    step;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk1("rst_rsp1_valid", rsp1_valid, 1'b0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("rst_alu_dr1", alu_dr1, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_ops_done", 32'(ops_done), 32'd0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    rst_n = 1'b1;
    // single ADD from requester 0
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 3'b001;
    #1;
    chk1("add_req0_ready", req0_ready, 1'b1);
    chk1("add_req1_ready", req1_ready, 1'b0);
    step;
    req0_valid = 1'b0;
    chk1("add_exec_busy", busy, 1'b1);
    chk("add_exec_dr1", alu_dr1, 32'd5);
    chk("add_exec_ctrl", 32'(alu_ctrl), 32'd1);
    chk1("add_exec_rsp0_valid", rsp0_valid, 1'b0);
    step;
    chk1("add_rsp0_valid", rsp0_valid, 1'b1);
    chk1("add_rsp1_valid", rsp1_valid, 1'b0);
    chk("add_result", rsp_result, 32'd8);
    chk1("add_err", rsp_err, 1'b0);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    step;
    chk("add_ops_done", 32'(ops_done), 32'd1);
    chk1("add_idle_busy", busy, 1'b0);
    // round-robin tie from a fresh reset: grants 0,1,0,1
    pulse_reset;
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd4; req0_op = 3'b010;
    req1_valid = 1'b1; req1_a = 32'hFF; req1_b = 32'h0F; req1_op = 3'b110;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk1("rr_req0_ready", req0_ready, k % 2 == 0);
      chk1("rr_req1_ready", req1_ready, k % 2 == 1);
      step;
      chk1("rr_exec_ready", req0_ready || req1_ready, 1'b0);
      step;
      chk1("rr_rsp0_valid", rsp0_valid, k % 2 == 0);
      chk1("rr_rsp1_valid", rsp1_valid, k % 2 == 1);
      chk("rr_result", rsp_result, k % 2 == 0 ? 32'd6 : 32'hF0);
      step;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr_ops_done", 32'(ops_done), 32'd4);
    // fixed priority: requester 0 always wins; 2-bit counter wraps after 4 ops
    f_rsp0_ready = 1'b1; f_rsp1_ready = 1'b1;
    f_req0_valid = 1'b1; f_req0_a = 32'd10; f_req0_b = 32'd4; f_req0_op = 3'b010;
    f_req1_valid = 1'b1; f_req1_a = 32'hFF; f_req1_b = 32'h0F; f_req1_op = 3'b110;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("fp_ops_done", 32'(f_ops_done), 32'(k));
      chk1("fp_req0_ready", f_req0_ready, 1'b1);
      chk1("fp_req1_ready", f_req1_ready, 1'b0);
      step;
      step;
      chk1("fp_rsp0_valid", f_rsp0_valid, 1'b1);
      chk1("fp_rsp1_valid", f_rsp1_valid, 1'b0);
      chk("fp_result", f_rsp_result, 32'd6);
      step;
    end
    f_req0_valid = 1'b0; f_req1_valid = 1'b0;
    chk("fp_wrap", 32'(f_ops_done), 32'd0);
    // backpressure on requester 1; requester 0's rsp_ready must be ignored
    rsp1_ready = 1'b0; rsp0_ready = 1'b1;
    req1_valid = 1'b1; req1_a = 32'd0; req1_b = 32'd0; req1_op = 3'b111;
    #1;
    chk1("bp_req1_ready", req1_ready, 1'b1);
    step;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 3'b001;
    #1;
    chk1("bp_exec_req0_ready", req0_ready, 1'b0);
    step;
    for (int k = 0; k < 5; k++) begin
      chk1("bp_rsp1_valid", rsp1_valid, 1'b1);
      chk1("bp_rsp0_valid", rsp0_valid, 1'b0);
      chk("bp_result", rsp_result, 32'hFFFF_FFFF);
      chk1("bp_busy", busy, 1'b1);
      chk1("bp_req0_ready", req0_ready, 1'b0);
      step;
    end
    rsp1_ready = 1'b1;
    #1;
    chk1("bp_exit_req0_ready", req0_ready, 1'b0);
    step;
    chk1("bp_after_req0_ready", req0_ready, 1'b1);
    chk1("bp_after_rsp1_valid", rsp1_valid, 1'b0);
    step;
    req0_valid = 1'b0;
    step;
    chk("bp_req0_result", rsp_result, 32'd3);
    step;
    chk("bp_ops_done", 32'(ops_done), 32'd6);
    // op 000
    req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9; req0_op = 3'b000;
    #1;
    chk1("op0_ready", req0_ready, 1'b1);
    step;
    req0_valid = 1'b0;
    chk("op0_alu_ctrl", 32'(alu_ctrl), 32'd0);
`ifdef ALU_ARB_OPCHECK_EN
    chk1("op0_rsp0_valid", rsp0_valid, 1'b1);
    chk1("op0_err", rsp_err, 1'b1);
    chk("op0_result", rsp_result, 32'd0);
    step;
`else
    chk1("op0_exec_rsp0_valid", rsp0_valid, 1'b0);
    step;
    chk1("op0_rsp0_valid", rsp0_valid, 1'b1);
    chk1("op0_err", rsp_err, 1'b0);
    chk("op0_result", rsp_result, 32'd0);
    step;
`endif
    chk("op0_ops_done", 32'(ops_done), 32'd7);
    // reset during EXEC drops the operation
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 3'b001;
    step;
    req0_valid = 1'b0;
    chk1("rx_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rx_alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("rx_alu_dr1", alu_dr1, 32'd0);
    chk1("rx_busy_low", busy, 1'b0);
    chk("rx_ops_done", 32'(ops_done), 32'd0);
    rst_n = 1'b1;
    step;
    step;
    chk1("rx_no_rsp", rsp0_valid, 1'b0);
    chk1("rx_idle", busy, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
